// File: rtl/handshake_sender.sv
// Four-phase request/acknowledge sender: accepts one payload from a valid/ready source,
// holds it on o_data and runs the req/ack handshake, flagging a stalled ack with a timeout pulse.
module handshake_sender #(
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_valid,
    input  logic [DATA_WIDTH-1:0] i_data,
    output logic                  o_ready,
    output logic                  o_req,
    output logic [DATA_WIDTH-1:0] o_data,
    input  logic                  i_ack,
    output logic                  o_busy,
    output logic                  o_timeout
);

    // A zero limit still needs a 1-bit counter so the vector stays legal; it never counts.
    localparam int unsigned CntW = (TIMEOUT_CYCLES == 0) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CntW-1:0] CntMax = CntW'(TIMEOUT_CYCLES);
    localparam bit TimeoutEn = (TIMEOUT_CYCLES != 0);

    typedef enum logic [1:0] {
        StIdle,
        StReqHigh,
        StReqLow
    } state_e;

    state_e                state_q, state_d;
    logic                  req_q, req_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic [CntW-1:0]       cnt_q, cnt_d;
    logic                  timeout_q, timeout_d;
    logic                  busy_q, busy_d;

    assign o_ready   = (state_q == StIdle) && !i_ack;
    assign o_req     = req_q;
    assign o_data    = data_q;
    assign o_busy    = busy_q;
    assign o_timeout = timeout_q;

    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        data_d  = data_q;
        case (state_q)
            StIdle: begin
                if (i_valid && !i_ack) begin
                    state_d = StReqHigh;
                    req_d   = 1'b1;
                    data_d  = i_data;
                end
            end
            StReqHigh: begin
                if (i_ack) begin
                    state_d = StReqLow;
                    req_d   = 1'b0;
                end
            end
            StReqLow: begin
                if (!i_ack) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
                req_d   = 1'b0;
            end
        endcase
    end

    // Counter restarts on any state change; the pulse fires only on the cycle it lands on the limit.
    always_comb begin
        cnt_d     = '0;
        timeout_d = 1'b0;
        if (TimeoutEn && (state_q != StIdle) && (state_d == state_q)) begin
            if (cnt_q != CntMax) begin
                cnt_d = cnt_q + CntW'(1);
            end else begin
                cnt_d = cnt_q;
            end
            timeout_d = (cnt_q != CntMax) && (cnt_d == CntMax);
        end
        busy_d = (state_d != StIdle);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q   <= StIdle;
            req_q     <= 1'b0;
            data_q    <= '0;
            cnt_q     <= '0;
            timeout_q <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            req_q     <= req_d;
            data_q    <= data_d;
            cnt_q     <= cnt_d;
            timeout_q <= timeout_d;
            busy_q    <= busy_d;
        end
    end

endmodule

// File: tb/tb_handshake_sender.sv
// Directed bench for handshake_sender: one instance with an 8-cycle timeout and one with
// timeout disabled, both driven by the same stimulus.
module tb_handshake_sender;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        valid;
    logic        ack;
    logic [31:0] data;

    logic        ready,  req,  busy,  tout;
    logic [31:0] odata;
    logic        ready0, req0, busy0, tout0;
    logic [31:0] odata0;

    int checks = 0;
    int errors = 0;
    int to8    = 0;
    int to0    = 0;

    handshake_sender #(.DATA_WIDTH(32), .TIMEOUT_CYCLES(8)) dut (
        .i_clk    (clk),
        .i_rst_n  (rst_n),
        .i_valid  (valid),
        .i_data   (data),
        .o_ready  (ready),
        .o_req    (req),
        .o_data   (odata),
        .i_ack    (ack),
        .o_busy   (busy),
        .o_timeout(tout)
    );

    handshake_sender #(.DATA_WIDTH(32), .TIMEOUT_CYCLES(0)) dut0 (
        .i_clk    (clk),
        .i_rst_n  (rst_n),
        .i_valid  (valid),
        .i_data   (data),
        .o_ready  (ready0),
        .o_req    (req0),
        .o_data   (odata0),
        .i_ack    (ack),
        .o_busy   (busy0),
        .o_timeout(tout0)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (tout)  to8++;
        if (tout0) to0++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int          n_xfer;
        int          first_e;
        int          base8;
        logic [1:0]  pipe;
        logic        pbusy;
        logic        preq;
        logic [31:0] pdata;

        rst_n = 1'b0;
        valid = 1'b0;
        ack   = 1'b0;
        data  = '0;
        #1;
        chk1("rst_req", req, 1'b0);
        chk ("rst_data", odata, 32'h0);
        chk1("rst_busy", busy, 1'b0);
        chk1("rst_timeout", tout, 1'b0);
        chk1("rst_ready", ready, 1'b1);
        tick();
        tick();
        rst_n = 1'b1;

        // Single transfer, ack rises 4 cycles after req and falls 4 after req drops
        valid = 1'b1;
        data  = 32'hDEADBEEF;
        #1;
        chk1("single_ready_idle", ready, 1'b1);
        tick();
        valid = 1'b0;
        data  = 32'h12345678;
        chk1("single_req_up", req, 1'b1);
        chk ("single_data", odata, 32'hDEADBEEF);
        chk1("single_busy", busy, 1'b1);
        chk1("single_ready_busy", ready, 1'b0);
        for (int i = 1; i <= 4; i++) begin
            tick();
            chk1("single_req_hold", req, 1'b1);
            chk ("single_data_hold", odata, 32'hDEADBEEF);
        end
        ack = 1'b1;
        tick();
        chk1("single_req_drop", req, 1'b0);
        chk1("single_busy_low", busy, 1'b1);
        chk ("single_data_low", odata, 32'hDEADBEEF);
        for (int i = 1; i <= 4; i++) begin
            tick();
            chk1("single_reqlow_busy", busy, 1'b1);
            chk1("single_reqlow_ready", ready, 1'b0);
        end
        ack = 1'b0;
        #1;
        chk1("single_ready_still_low", ready, 1'b0);
        tick();
        chk1("single_idle", busy, 1'b0);
        chk1("single_ready_back", ready, 1'b1);
        chk ("single_data_after", odata, 32'hDEADBEEF);

        // Back-to-back transfers with a 2-cycle ack loopback
        valid   = 1'b1;
        data    = 32'h1;
        pipe    = 2'b00;
        n_xfer  = 0;
        first_e = 0;
        for (int cyc = 1; cyc <= 80 && (n_xfer < 3 || busy); cyc++) begin
            pbusy = busy;
            preq  = req;
            pdata = odata;
            tick();
            if (pbusy) chk("b2b_hold", odata, pdata);
            if (!preq && req) begin
                n_xfer++;
                chk("b2b_order", odata, n_xfer);
                if (n_xfer == 1) first_e = cyc;
                if (n_xfer == 2) chk("b2b_period", cyc - first_e, 7);
                if (n_xfer < 3) data = n_xfer + 1;
                else valid = 1'b0;
            end
            ack  = pipe[1];
            pipe = {pipe[0], req};
        end
        ack = 1'b0;
        chk("b2b_count", n_xfer, 3);
        chk("b2b_final_data", odata, 32'h3);
        chk("b2b_no_timeout", to8, 0);

        // Timeout with ack withheld
        tick();
        valid = 1'b1;
        data  = 32'hA5;
        tick();
        valid = 1'b0;
        for (int i = 1; i <= 7; i++) begin
            tick();
            chk1("to_early", tout, 1'b0);
        end
        tick();
        chk1("to_pulse", tout, 1'b1);
        chk1("to_req_kept", req, 1'b1);
        chk1("to_disabled", tout0, 1'b0);
        for (int i = 9; i <= 20; i++) begin
            tick();
            chk1("to_no_repeat", tout, 1'b0);
            chk1("to_req_stays", req, 1'b1);
            chk ("to_data_stays", odata, 32'hA5);
        end
        chk("to_pulse_count", to8, 1);
        ack = 1'b1;
        tick();
        chk1("to_complete_req", req, 1'b0);
        ack = 1'b0;
        tick();
        chk1("to_complete_idle", busy, 1'b0);
        chk1("to_complete_ready", ready, 1'b1);

        // Stale ack in IDLE blocks acceptance
        ack   = 1'b1;
        valid = 1'b1;
        data  = 32'h77;
        #1;
        chk1("stale_ready", ready, 1'b0);
        for (int i = 1; i <= 5; i++) begin
            tick();
            chk1("stale_busy", busy, 1'b0);
            chk1("stale_req", req, 1'b0);
            chk ("stale_data", odata, 32'hA5);
        end
        ack = 1'b0;
        #1;
        chk1("stale_ready_back", ready, 1'b1);
        tick();
        valid = 1'b0;
        chk1("stale_xfer_req", req, 1'b1);
        chk ("stale_xfer_data", odata, 32'h77);

        // Reset asserted in REQ_LOW
        ack = 1'b1;
        tick();
        chk1("rlow_req", req, 1'b0);
        chk1("rlow_busy", busy, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        chk1("rlow_rst_req", req, 1'b0);
        chk ("rlow_rst_data", odata, 32'h0);
        chk ("rlow_rst_data0", odata0, 32'h0);
        chk1("rlow_rst_busy", busy, 1'b0);
        chk1("rlow_rst_timeout", tout, 1'b0);
        tick();
        tick();
        rst_n = 1'b1;
        valid = 1'b1;
        data  = 32'h99;
        #1;
        chk1("rlow_rel_ready", ready, 1'b0);
        for (int i = 1; i <= 2; i++) begin
            tick();
            chk1("rlow_rel_busy", busy, 1'b0);
            chk1("rlow_rel_req", req, 1'b0);
        end
        ack = 1'b0;
        #1;
        chk1("rlow_ready_back", ready, 1'b1);
        tick();
        valid = 1'b0;
        chk1("rlow_xfer_req", req, 1'b1);
        chk ("rlow_xfer_data", odata, 32'h99);
        ack = 1'b1;
        tick();
        ack = 1'b0;
        tick();
        chk1("rlow_done", busy, 1'b0);

        // Long ack stall: disabled timeout stays silent, enabled one fires once
        valid = 1'b1;
        data  = 32'hC3;
        tick();
        valid = 1'b0;
        base8 = to8;
        to0   = 0;
        repeat (5000) tick();
        chk("long_no_timeout0", to0, 0);
        chk("long_one_timeout8", to8 - base8, 1);
        chk1("long_req0", req0, 1'b1);
        chk ("long_data0", odata0, 32'hC3);
        ack = 1'b1;
        tick();
        ack = 1'b0;
        tick();
        chk1("long_done", busy0, 1'b0);
        chk1("long_done_ready", ready0, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
